mining_scheduler: RTL and testbench

//  Sequences mining jobs onto the core array and nonce decoder. Accepts job IDs from the host

---
 rtl/mining_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mining_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mining_scheduler.sv
// Job sequencer for the core array: 1-entry job buffer, newblock + broadcast beats,
// decoder verdict / timeout / abort resolution, and a held result on a valid/ready port.
module mining_scheduler #(
    parameter int NUM_CORES     = 10,
    parameter int BROADCAST_CNT = 100,
    parameter int ID_W          = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            job_valid_i,
    input  logic [ID_W-1:0] job_id_i,
    output logic            job_ready_o,
    input  logic            abort_i,
    input  logic            hold_i,
    output logic            newblock_o,
    output logic            valid_o,
    input  logic            dec_valid_i,
    input  logic            dec_success_i,
    input  logic [31:0]     dec_nonce_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [ID_W-1:0] res_id_o,
    output logic            res_success_o,
    output logic [31:0]     res_nonce_o,
    output logic            res_timeout_o,
    output logic            res_abort_o,
    output logic            busy_o
);
    localparam int BEAT_W = $clog2(BROADCAST_CNT + 1);
    localparam int TMO_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BROADCAST_CNT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DRAIN_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    if (NUM_CORES < 1) begin : g_chk_cores
        $error("NUM_CORES must be >= 1");
    end
    if (DRAIN_TIMEOUT < 1) begin : g_chk_tmo
        $error("DRAIN_TIMEOUT must be >= 1");
    end

    logic [2:0]        state_q, state_d;
    logic              pend_full_q, pend_full_d;
    logic [ID_W-1:0]   pend_id_q, pend_id_d;
    logic [ID_W-1:0]   active_q, active_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              res_succ_q, res_tmo_q, res_abort_q;
    logic [31:0]       res_nonce_q;

    logic accept, take, beat_issue;
    logic fin, fin_succ, fin_tmo, fin_abort;

    assign accept     = job_valid_i && !pend_full_q;
    assign beat_issue = (state_q == S_RUN) && !hold_i;

    assign job_ready_o   = !pend_full_q;
    assign newblock_o    = (state_q == S_LOAD);
    assign valid_o       = (state_q == S_LOAD) || beat_issue;
    assign busy_o        = (state_q != S_IDLE);
    assign res_valid_o   = (state_q == S_RESULT);
    assign res_id_o      = active_q;
    assign res_success_o = res_succ_q;
    assign res_nonce_o   = res_nonce_q;
    assign res_timeout_o = res_tmo_q;
    assign res_abort_o   = res_abort_q;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        take      = 1'b0;
        fin       = 1'b0;
        fin_succ  = 1'b0;
        fin_tmo   = 1'b0;
        fin_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_full_q) begin
                    take    = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                beat_d  = '0;
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (beat_issue) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: tmo_d = tmo_q + TMO_W'(1);
            S_RESULT: begin
                if (res_ready_i) begin
                    take    = pend_full_q;
                    state_d = pend_full_q ? S_LOAD : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats a same-cycle verdict; a verdict beats the last timeout cycle.
        if (state_q inside {S_LOAD, S_RUN, S_DRAIN}) begin
            if (abort_i) begin
                fin       = 1'b1;
                fin_abort = 1'b1;
            end else if (dec_valid_i) begin
                fin      = 1'b1;
                fin_succ = dec_success_i;
            end else if (state_q == S_DRAIN && tmo_q == TMO_LAST) begin
                fin     = 1'b1;
                fin_tmo = 1'b1;
            end
        end
        if (fin) state_d = S_RESULT;
    end

    always_comb begin
        pend_full_d = pend_full_q;
        pend_id_d   = pend_id_q;
        active_d    = active_q;
        if (accept) begin
            pend_full_d = 1'b1;
            pend_id_d   = job_id_i;
        end else if (take) begin
            pend_full_d = 1'b0;
        end
        if (take) active_d = pend_id_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pend_full_q <= 1'b0;
            pend_id_q   <= '0;
            active_q    <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            res_succ_q  <= 1'b0;
            res_tmo_q   <= 1'b0;
            res_abort_q <= 1'b0;
            res_nonce_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            pend_id_q   <= pend_id_d;
            active_q    <= active_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            if (fin) begin
                res_succ_q  <= fin_succ;
                res_tmo_q   <= fin_tmo;
                res_abort_q <= fin_abort;
                res_nonce_q <= fin_succ ? dec_nonce_i : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_mining_scheduler.sv
// Job-level bench: each job's beat count, latencies and result tuple are predicted
// from the scenario the bench drives (hold window, verdict timing, abort, stall).
module tb_mining_scheduler;
    localparam int BC = 100;
    localparam int DT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_valid_i = 1'b0;
    logic [7:0]  job_id_i = '0;
    logic        job_ready_o;
    logic        abort_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        newblock_o, valid_o;
    logic        dec_valid_i = 1'b0;
    logic        dec_success_i = 1'b0;
    logic [31:0] dec_nonce_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [7:0]  res_id_o;
    logic        res_success_o;
    logic [31:0] res_nonce_o;
    logic        res_timeout_o, res_abort_o, busy_o;

    mining_scheduler #(.NUM_CORES(10), .BROADCAST_CNT(BC), .ID_W(8), .DRAIN_TIMEOUT(DT)) dut (
        .clk(clk), .rst(rst),
        .job_valid_i(job_valid_i), .job_id_i(job_id_i), .job_ready_o(job_ready_o),
        .abort_i(abort_i), .hold_i(hold_i),
        .newblock_o(newblock_o), .valid_o(valid_o),
        .dec_valid_i(dec_valid_i), .dec_success_i(dec_success_i), .dec_nonce_i(dec_nonce_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
        .res_success_o(res_success_o), .res_nonce_o(res_nonce_o),
        .res_timeout_o(res_timeout_o), .res_abort_o(res_abort_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chained = 0;
    int carry_beats = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_job_ready"}, job_ready_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_newblock"}, newblock_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_res_valid"}, res_valid_o, 0);
        chk({tag, "_res_fields"}, {res_id_o, res_success_o, res_nonce_o, res_timeout_o, res_abort_o}, 0);
    endtask

    task automatic offer(input logic [7:0] id);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            job_valid_i = 1'b1;
            job_id_i    = id;
            #1;
            ok = job_ready_o;
        end
        chk("offer_accepted", ok, 1);
        @(negedge clk);
        job_valid_i = 1'b0;
    endtask

    // mode 0: verdict k cycles into DRAIN; 1: no verdict (timeout);
    // 2: verdict at offset k from newblock; 3: abort at offset k (optionally with verdict)
    task automatic run_job(input logic [7:0] id, input int mode, input int k,
                           input int hs, input int hl, input bit succ, input logic [31:0] nonce,
                           input bit dec_with_abort, input int stall,
                           input bit nxt_v, input logic [7:0] nxt_id);
        bit started = chained;
        bit done = 0;
        int off = 0, nb = 0, beats = 0, last = -1, wait_n = 0, res_off = -1;
        int stall_left = stall;
        bit e_succ, e_tmo, e_ab;
        logic [31:0] e_nonce;
        int e_off, e_beats;
        e_succ  = (mode == 0 || mode == 2) ? succ : 1'b0;
        e_nonce = e_succ ? nonce : 32'd0;
        e_tmo   = (mode == 1);
        e_ab    = (mode == 3);
        if (chained) begin
            nb = 1;
            beats = carry_beats;
            last = 0;
        end
        chained = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (started) off++;
            hold_i      = started && off >= hs && off < hs + hl;
            dec_valid_i = 1'b0;
            abort_i     = 1'b0;
            if (started && off == 2) job_valid_i = 1'b0;
            #1;
            if (!started) begin
                wait_n++;
                if (newblock_o) begin
                    started = 1;
                    off = 0;
                    chk("load_latency", wait_n, 1);
                end
            end
            if (started) nb += int'(newblock_o);
            if (started && res_off < 0) begin
                beats += int'(valid_o);
                if (valid_o) last = off;
                if (res_valid_o) begin
                    res_off = off;
                    e_beats = (mode < 2) ? BC + 1 : k + 1;
                    e_off = (mode == 0) ? last + 2 + k : (mode == 1) ? last + 1 + DT : k + 1;
                    chk("beats", beats, e_beats);
                    chk("result_latency", res_off, e_off);
                    if (mode < 2) chk("run_length", last, BC + hl);
                    chk("job_ready_while_pending", job_ready_o, !nxt_v);
                end
            end
            if (res_off >= 0) begin
                chk("res_valid", res_valid_o, 1);
                chk("res_id", res_id_o, id);
                chk("res_tuple", {res_success_o, res_nonce_o, res_timeout_o, res_abort_o},
                    {e_succ, e_nonce, e_tmo, e_ab});
                if (stall_left == 0) begin
                    res_ready_i = 1'b1;
                    done = 1;
                end else begin
                    stall_left--;
                end
            end else if (started) begin
                if (nxt_v && off == 1) begin
                    chk("pend_empty_in_run", job_ready_o, 1);
                    job_valid_i = 1'b1;
                    job_id_i    = nxt_id;
                end
                if ((mode == 0 && beats == BC + 1 && off == last + 1 + k) ||
                    (mode == 2 && off == k)) begin
                    dec_valid_i   = 1'b1;
                    dec_success_i = succ;
                    dec_nonce_i   = nonce;
                end
                if (mode == 3 && off == k) begin
                    abort_i       = 1'b1;
                    dec_valid_i   = dec_with_abort;
                    dec_success_i = 1'b1;
                    dec_nonce_i   = $urandom | 32'h1;
                end
            end
        end
        chk("job_completed", done, 1);
        chk("newblock_count", nb, 1);
        @(negedge clk);
        res_ready_i = 1'b0;
        job_valid_i = 1'b0;
        hold_i      = 1'b0;
        #1;
        chk("after_hs_newblock", newblock_o, nxt_v);
        chk("after_hs_res_valid", res_valid_o, 0);
        chk("after_hs_busy", busy_o, nxt_v);
        chained = nxt_v;
        carry_beats = int'(valid_o);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cur_id, nid;
        int mode, k, hs, hl, stall;
        bit nv, saw;
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk_idle_outputs("in_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("post_reset");

        // 1: plain success, verdict two cycles into DRAIN
        offer(8'h11);
        run_job(8'h11, 0, 2, 0, 0, 1'b1, 32'h3E7, 1'b0, 0, 1'b0, 8'h0);
        // 2: 5-cycle hold mid-RUN, failed verdict -> nonce forced 0
        offer(8'h22);
        run_job(8'h22, 0, 7, 40, 5, 1'b0, 32'h1234, 1'b0, 1, 1'b0, 8'h0);
        // 3: timeout
        offer(8'h33);
        run_job(8'h33, 1, 0, 0, 0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 8'h0);
        // 4: back-to-back, zero-bubble restart
        offer(8'hA1);
        run_job(8'hA1, 0, 3, 0, 0, 1'b1, 32'hCAFE, 1'b0, 0, 1'b1, 8'hA2);
        run_job(8'hA2, 0, 1, 0, 0, 1'b1, 32'hBEEF, 1'b0, 0, 1'b0, 8'h0);
        // 5: abort with simultaneous verdict in RUN, result stalled 3 cycles
        offer(8'h5A);
        run_job(8'h5A, 3, 40, 0, 0, 1'b0, 32'h0, 1'b1, 3, 1'b0, 8'h0);

        // 6: reset mid-RUN with a job pending
        offer(8'h66);
        saw = 0;
        for (int i = 0; i < 10 && !saw; i++) begin
            @(negedge clk);
            #1;
            saw = newblock_o;
        end
        chk("reset_test_started", saw, 1);
        @(negedge clk);
        job_valid_i = 1'b1;
        job_id_i    = 8'h67;
        repeat (10) @(negedge clk);
        job_valid_i = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("after_midrun_reset");
        repeat (3) @(negedge clk);
        #1;
        chk("pending_lost_busy", busy_o, 0);
        offer(8'h77);
        run_job(8'h77, 0, 4, 10, 3, 1'b1, 32'h0BAD_F00D, 1'b0, 0, 1'b0, 8'h0);

        // randomized jobs
        cur_id = 8'($urandom);
        for (int j = 0; j < 12; j++) begin
            mode  = $urandom_range(0, 3);
            stall = $urandom_range(0, 4);
            hs    = $urandom_range(1, BC);
            hl    = (mode < 2) ? $urandom_range(0, 8) : 0;
            k     = (mode == 0) ? $urandom_range(0, DT - 1) : (mode >= 2) ? $urandom_range(1, BC) : 0;
            nv    = (j < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
            nid   = 8'($urandom);
            if (!chained) offer(cur_id);
            run_job(cur_id, mode, k, hs, hl, 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), stall, nv, nid);
            cur_id = nid;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
